// File: rtl/binary_search_pkg.sv
// Shared types and constants for the binary search accelerator.
// Used by the controller, the datapath and the top level.
package binary_search_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int SIZE_W = ADDR_W + 1;

  localparam logic [SIZE_W-1:0] SIZE_INIT = 6'd32;
  localparam logic [SIZE_W-1:0] SIZE_LAST = 6'd2;
  localparam logic [ADDR_W-1:0] ADDR_INIT = 5'd16;
  localparam logic [ADDR_W-1:0] ADDR_ZERO_PRE = 5'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CMP,
    S_ZWAIT,
    S_ZCMP,
    S_DONE
  } state_t;

endpackage

// File: rtl/binary_search_ctrl_if.sv
// Control bundle between the search FSM and the datapath/RAM side.
// master: the FSM; slave: datapath, RAM and the user start level.
interface binary_search_ctrl_if;
  import binary_search_pkg::*;

  logic              start;
  logic [DATA_W-1:0] data_ans;
  logic [SIZE_W-1:0] size;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] q;
  logic              load_data;
  logic              data_big;
  logic              data_small;
  logic              found_ctrl;
  logic              notFound_ctrl;
  logic              check_zero;
  logic              done;

  modport master (
    input  start,
    input  data_ans,
    input  size,
    input  address,
    input  q,
    output load_data,
    output data_big,
    output data_small,
    output found_ctrl,
    output notFound_ctrl,
    output check_zero,
    output done
  );

  modport slave (
    output start,
    output data_ans,
    output size,
    output address,
    output q,
    input  load_data,
    input  data_big,
    input  data_small,
    input  found_ctrl,
    input  notFound_ctrl,
    input  check_zero,
    input  done
  );

endinterface

// File: rtl/binary_search_ctrl.sv
// Search control FSM: sequences RAM reads, compares q to data_ans
// and issues one-hot datapath strobes, including the address-0 probe.
module binary_search_ctrl
  import binary_search_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  binary_search_ctrl_if.master bus
);

  state_t state;
  state_t state_nx;

  logic eq;
  logic lt;
  logic last;
  logic zpre;

  assign eq   = bus.q == bus.data_ans;
  assign lt   = bus.q < bus.data_ans;
  assign last = bus.size <= SIZE_LAST;
  assign zpre = bus.address == ADDR_ZERO_PRE;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    bus.load_data     = 1'b0;
    bus.data_big      = 1'b0;
    bus.data_small    = 1'b0;
    bus.found_ctrl    = 1'b0;
    bus.notFound_ctrl = 1'b0;
    bus.check_zero    = 1'b0;
    bus.done          = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_nx = S_WAIT;
        else           bus.load_data = 1'b1;
      end
      S_WAIT: state_nx = S_CMP;
      S_CMP: begin
        unique case (1'b1)
          eq: begin
            bus.found_ctrl = 1'b1;
            state_nx       = S_DONE;
          end
          !eq && !last && lt: begin
            bus.data_big = 1'b1;
            state_nx     = S_WAIT;
          end
          !eq && !last && !lt: begin
            bus.data_small = 1'b1;
            state_nx       = S_WAIT;
          end
          // address 0 is below the halving tree; probe it last
          !eq && last && !lt && zpre: begin
            bus.check_zero = 1'b1;
            state_nx       = S_ZWAIT;
          end
          default: begin
            bus.notFound_ctrl = 1'b1;
            state_nx          = S_DONE;
          end
        endcase
      end
      S_ZWAIT: state_nx = S_ZCMP;
      S_ZCMP: begin
        if (eq) bus.found_ctrl    = 1'b1;
        else    bus.notFound_ctrl = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (!bus.start) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (reset) begin
      bus.load_data     = 1'b0;
      bus.data_big      = 1'b0;
      bus.data_small    = 1'b0;
      bus.found_ctrl    = 1'b0;
      bus.notFound_ctrl = 1'b0;
      bus.check_zero    = 1'b0;
      bus.done          = 1'b0;
    end
  end

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Bench for binary_search_ctrl with a datapath/RAM model around it
// and a scoreboard of expected search outcomes.
module tb_binary_search_ctrl;
  import binary_search_pkg::*;

  typedef struct {
    int              t0;
    logic            found;
    logic [ADDR_W-1:0] addr;
    int              lat;
    int              cz;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DATA_W-1:0] data_i = '0;
  logic found = 1'b0;
  logic not_found = 1'b0;
  logic [DATA_W-1:0] mem [32];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int cz_cnt = 0;
  logic done_q = 1'b0;
  exp_t exp_q[$];

  binary_search_ctrl_if bus();

  binary_search_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // datapath and synchronous RAM environment
  always @(posedge clk) begin
    bus.q <= mem[bus.address];
    if (reset) begin
      bus.address  <= ADDR_INIT;
      bus.size     <= SIZE_INIT;
      bus.data_ans <= '0;
      found        <= 1'b0;
      not_found    <= 1'b0;
    end else if (bus.load_data) begin
      bus.address  <= ADDR_INIT;
      bus.size     <= SIZE_INIT;
      bus.data_ans <= data_i;
      found        <= 1'b0;
      not_found    <= 1'b0;
    end else if (bus.data_big) begin
      bus.address <= bus.address + ADDR_W'(bus.size >> 2);
      bus.size    <= bus.size >> 1;
    end else if (bus.data_small) begin
      bus.address <= bus.address - ADDR_W'(bus.size >> 2);
      bus.size    <= bus.size >> 1;
    end else if (bus.check_zero) begin
      bus.address <= '0;
    end else if (bus.found_ctrl) begin
      found <= 1'b1;
    end else if (bus.notFound_ctrl) begin
      not_found <= 1'b1;
    end
  end

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic int tz(int v);
    int n = 0;
    while (n < 5 && v[n] == 1'b0) n++;
    return n;
  endfunction

  // outcome from rank arithmetic over a sorted, distinct table
  function automatic exp_t model(logic [DATA_W-1:0] t);
    exp_t e;
    int idx = -1;
    int j = 0;
    e.t0 = 0;
    e.cz = 0;
    for (int i = 0; i < 32; i++)
      if (mem[i] == t) idx = i;
    if (idx >= 0) begin
      e.found = 1'b1;
      e.addr  = ADDR_W'(idx);
      if (idx == 0) begin
        e.lat = 12;
        e.cz  = 1;
      end else begin
        e.lat = 2 * (5 - tz(idx));
      end
    end else if (t < mem[1]) begin
      e.found = 1'b0;
      e.addr  = '0;
      e.lat   = 12;
      e.cz    = 1;
    end else begin
      for (int i = 1; i < 32; i++)
        if (mem[i] < t) j = i;
      e.found = 1'b0;
      e.addr  = ADDR_W'((j % 2 == 1) ? j : j + 1);
      e.lat   = 10;
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon
    int n;
    exp_t e;
    n = int'(bus.load_data) + int'(bus.data_big) +
        int'(bus.data_small) + int'(bus.found_ctrl) +
        int'(bus.notFound_ctrl) + int'(bus.check_zero);
    checks++;
    if (n > 1) begin
      errors++;
      $display("FAIL onehot strobes=%0d required<=1", n);
    end
    if (reset) chk("reset_quiet", n + int'(bus.done), 0);
    if (bus.load_data)       cz_cnt = 0;
    else if (bus.check_zero) cz_cnt++;
    if (bus.done && !done_q) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("found", int'(found), int'(e.found));
        chk("not_found", int'(not_found), int'(!e.found));
        chk("address", int'(bus.address), int'(e.addr));
        chk("latency", cyc - e.t0, e.lat);
        chk("check_zero_cnt", cz_cnt, e.cz);
      end
    end
    done_q = bus.done;
  end

  task automatic search(input logic [DATA_W-1:0] t, input bit drop);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b0;
    data_i = t;
    repeat (2) @(negedge clk);
    e = model(t);
    e.t0 = cyc + 1;
    exp_q.push_back(e);
    bus.start = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
      @(negedge clk);
      if (drop && n == 2) bus.start = 1'b0;
    end
    chk("timeout_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = DATA_W'(2 * i);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_load", int'(bus.load_data), 1);
    chk("post_reset_done", int'(bus.done), 0);

    search(8'd34, 1'b0);
    search(8'd35, 1'b0);
    search(8'd0, 1'b0);
    search(8'd1, 1'b0);
    search(8'd32, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_done", int'(bus.done), 1);
      chk("hold_no_load", int'(bus.load_data), 0);
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("reload_after_done", int'(bus.load_data), 1);

    // reset lands on e5 of a search for 34
    data_i = 8'd34;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_done", int'(bus.done), 0);
    reset = 1'b0;
    #1;
    chk("rst_mid_load", int'(bus.load_data), 1);
    chk("rst_mid_addr", int'(bus.address), 16);
    chk("rst_mid_found", int'(found), 0);
    chk("rst_mid_nf", int'(not_found), 0);

    for (int a = 0; a < 6; a++) begin
      mem[0] = DATA_W'($urandom_range(0, 3));
      for (int i = 1; i < 32; i++)
        mem[i] = mem[i-1] + DATA_W'($urandom_range(1, 7));
      for (int s = 0; s < 10; s++) begin
        logic [DATA_W-1:0] t;
        if ($urandom_range(0, 1) == 0) t = mem[$urandom_range(0, 31)];
        else                           t = DATA_W'($urandom_range(0, 255));
        search(t, $urandom_range(0, 3) == 0);
      end
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_search_ctrl.md
Name: binary_search_ctrl

Overview:
- Control FSM for the 32-entry binary search accelerator; sits directly upstream of binary_search_datapath.
- Sequences synchronous-RAM reads, compares the RAM read word q against the datapath's latched data_ans, and issues one-hot control strobes: load_data, data_big, data_small, found_ctrl, notFound_ctrl, check_zero.
- Also handles the address-0 corner, which the halving arithmetic cannot reach (16−8−4−2−1 = 1).

Parameters:
- DATA_W, 8, width of data_ans and q.
- ADDR_W, 5, width of address; array depth is 2**ADDR_W.
- SIZE_W, 6, width of size (ADDR_W+1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  user start; level, held high for the whole search.
- data_ans  in  DATA_W  target value latched by the datapath.
- size  in  SIZE_W  current window size from the datapath (32,16,8,4,2).
- address  in  ADDR_W  current address from the datapath; also drives the RAM address.
- q  in  DATA_W  RAM read data; valid one edge after the address is sampled.
- load_data, data_big, data_small, found_ctrl, notFound_ctrl, check_zero  out  1 each  datapath strobes.
- done  out  1  high in S_DONE.

Behaviour:
- States: S_IDLE, S_WAIT, S_CMP, S_ZWAIT, S_ZCMP, S_DONE. State reset value is S_IDLE.
- All strobes are combinational from state, plus the q/data_ans compare in S_CMP and S_ZCMP.
- At most one strobe is high per cycle. All strobes and done are forced to 0 while reset is high.
- S_IDLE:
  - load_data=1 while start=0.
  - start=1 → S_WAIT, with load_data=0 in that cycle (data_ans/address/size were loaded on prior edges).
- S_WAIT: no strobes; → S_CMP. This covers the RAM read latency (address changes at edge E, RAM samples it at E+1).
- S_CMP:
  - q==data_ans → found_ctrl=1, → S_DONE.
  - q<data_ans and size>2 → data_big=1, → S_WAIT.
  - q>data_ans and size>2 → data_small=1, → S_WAIT.
  - size==2, mismatch, q>data_ans and address==1 → check_zero=1, → S_ZWAIT.
  - size==2, any other mismatch → notFound_ctrl=1, → S_DONE.
- S_ZWAIT: no strobes; → S_ZCMP.
- S_ZCMP:
  - q==data_ans → found_ctrl=1.
  - else notFound_ctrl=1.
  - Either way → S_DONE.
- S_DONE: done=1, no strobes. start=0 → S_IDLE; otherwise hold. Datapath found/notFound stay valid until the next load_data.
- Latency: start is sampled at edge e0. The k-th compare is evaluated in the cycle after edge e(2k−1), and its result registers in the datapath at e(2k).
  - Max normal search: 5 compares, result at e10.
  - Address-0 path: result at e12.
- Comparisons are unsigned on DATA_W bits.
- start dropping mid-search is ignored; the search completes and S_DONE falls straight through to S_IDLE.
- start held high after S_DONE: no new search starts until start returns low and S_IDLE reloads.
- reset mid-search: S_IDLE on the next edge; no strobe in the reset cycle.
- size value not in {32,16,8,4,2} in S_CMP (should not occur): treat size≤2 as the final step.

Decomposition:
- Package binary_search_pkg:
  - state_t enum.
  - DATA_W, ADDR_W, SIZE_W.
  - SIZE_INIT=32, ADDR_INIT=16, SIZE_LAST=2, ADDR_ZERO_PRE=1.
- Shared with binary_search_datapath and the top level.
- No sub-module: single FSM with the compare inline. The top level (binary_search_top) instantiates ctrl, datapath and the 32x8 RAM.

Test Plan:
- Use the integrated top with RAM mem[a]=2a.
- data_i=34, start=1 → path 16,24,20,18,17; found=1 at e10, address_o=17, done=1; notFound=0.
- data_i=35 → path ends at 17 (34<35, size 2); notFound=1 at e10, found=0; check_zero never asserted.
- data_i=0 → path 16,8,4,2,1; check_zero at the 5th compare; address_o=0 at e10; found=1 at e12.
- data_i=1 → same path to address 0; notFound=1 at e12.
- data_i=32 → found at the first compare, e2, address_o=16. Then hold start=1 for 5 cycles → stays in S_DONE. Then start=0 → load_data=1 next cycle.
- Reset asserted at e5 of the data_i=34 search → all strobes 0 during reset; S_IDLE after; address_o=16, found=0, notFound=0.
- Every cycle in every scenario: at most one strobe high (assertion).
